// File: rtl/sigmoid_pkg.sv
// Shared types and Q16 constants for the sigmoid arbiter slice.
// The optional grant counters are enabled with SIGMOID_ARB_STATS_EN.
package sigmoid_pkg;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] data_t;

    localparam int Q16_ONE  = 65536;
    localparam int Q16_HALF = 32768;
    localparam int SIG_SAT  = 4096;

endpackage

// File: rtl/sigmoid_arbiter_approx.sv
// Piecewise-linear sigmoid: saturates outside +/-SIG_SAT, otherwise x/4 + 0.5.
module sigmoid_approx
    import sigmoid_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);

    // Q16 constants rescaled to the configured fraction width
    localparam logic signed [DATA_WIDTH-1:0] ONE_V  = DATA_WIDTH'(Q16_ONE  >>> (16 - FRAC_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] HALF_V = DATA_WIDTH'(Q16_HALF >>> (16 - FRAC_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] SAT_P  = DATA_WIDTH'(SIG_SAT);
    localparam logic signed [DATA_WIDTH-1:0] SAT_N  = -SAT_P;

    // Three-segment approximation
    always_comb begin
        if (x >= SAT_P) begin
            y = ONE_V;
        end else if (x <= SAT_N) begin
            y = '0;
        end else begin
            y = (x >>> 2) + HALF_V;
        end
    end

endmodule

// File: rtl/sigmoid_arbiter_rr.sv
// Round-robin arbiter: searches upward from rr_ptr with wrap-around and
// returns a one-hot grant plus its index; the pointer moves past each winner.
module rr_arbiter
    import sigmoid_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any_grant
);

    logic [ID_W-1:0] rr_ptr_r;
    logic            found_s;
    int              idx_s;

    // Priority search starting at rr_ptr
    always_comb begin
        found_s  = 1'b0;
        grant_id = '0;
        idx_s    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = int'(rr_ptr_r) + k;
            if (idx_s >= N_REQ) begin
                idx_s = idx_s - N_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                found_s  = 1'b1;
                grant_id = ID_W'(idx_s);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant is only issued when the pipeline can take the operand
    always_comb begin
        grant           = '0;
        any_grant       = en & found_s;
        grant[grant_id] = en & found_s;
    end

    // Pointer advances past the winner on every fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (any_grant) begin
            rr_ptr_r <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// N_REQ requesters share one sigmoid datapath through a 2-stage pipeline.
// Define SIGMOID_ARB_STATS_EN to build saturating per-requester grant counters.
module sigmoid_arbiter
    import sigmoid_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16,
    parameter int CNT_W      = 16,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_x,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_y,
    output logic [ID_W-1:0]             out_id,
    output logic                        idle,
    input  logic                        stats_clr,
    output logic [N_REQ*CNT_W-1:0]      grant_cnt
);

    logic                         a_valid_r, b_valid_r;
    logic signed [DATA_WIDTH-1:0] a_x_r, b_y_r, sel_x_s, sig_y_s;
    logic [ID_W-1:0]              a_id_r, b_id_r, grant_id_s;
    logic [N_REQ-1:0]             grant_s;
    logic                         any_grant_s, a_adv_s, b_adv_s;

    assign b_adv_s = !b_valid_r | out_ready;
    assign a_adv_s = !a_valid_r | b_adv_s;

    // rst_n gates the enable so nothing is offered while reset is held
    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (a_adv_s & rst_n),
        .grant     (grant_s),
        .grant_id  (grant_id_s),
        .any_grant (any_grant_s)
    );

    assign req_ready = grant_s;
    assign sel_x_s   = req_x[int'(grant_id_s)*DATA_WIDTH +: DATA_WIDTH];

    sigmoid_approx #(.DATA_WIDTH(DATA_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_sig (
        .x (a_x_r),
        .y (sig_y_s)
    );

    // Stage A: operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_r <= 1'b0;
            a_x_r     <= '0;
            a_id_r    <= '0;
        end else if (a_adv_s) begin
            a_valid_r <= any_grant_s;
            a_x_r     <= sel_x_s;
            a_id_r    <= grant_id_s;
        end else begin
            a_valid_r <= a_valid_r;
        end
    end

    // Stage B: result register, holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_r <= 1'b0;
            b_y_r     <= '0;
            b_id_r    <= '0;
        end else if (b_adv_s) begin
            b_valid_r <= a_valid_r;
            b_y_r     <= sig_y_s;
            b_id_r    <= a_id_r;
        end else begin
            b_valid_r <= b_valid_r;
        end
    end

    assign out_valid = b_valid_r;
    assign out_y     = b_y_r;
    assign out_id    = b_id_r;
    assign idle      = !a_valid_r & !b_valid_r & !(|req_valid);

`ifdef SIGMOID_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_r [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        // Saturating grant counter; clear wins over increment
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r[i] <= '0;
            end else if (stats_clr) begin
                cnt_r[i] <= '0;
            end else if (grant_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign grant_cnt        = '0;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter: arithmetic, round-robin order,
// backpressure, mid-stream reset and (with SIGMOID_ARB_STATS_EN) grant counters.
module tb_sigmoid_arbiter;
    import sigmoid_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_x;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_y;
    logic [1:0]   out_id;
    logic         idle;
    logic         stats_clr;
    logic [63:0]  grant_cnt;

    int tests  = 0;
    int failed = 0;

    sigmoid_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id),
        .idle      (idle),
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input data_t v);
        req_x[i*32 +: 32] = v;
    endtask

    initial begin
        int    xs [5]    = '{0, 2048, -2048, 4096, -8192};
        int    ys [5]    = '{32768, 33280, 32256, 65536, 0};
        int    order [6] = '{0, 1, 2, 3, 0, 1};
        int    yv [4]    = '{32768, 33024, 33280, 33536};
        logic [3:0] alt [3] = '{4'b1000, 4'b0010, 4'b1000};
        int    acc;

        rst_n = 1'b0; req_valid = 4'b0000; req_x = 128'd0;
        out_ready = 1'b0; stats_clr = 1'b0;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_grant_cnt", grant_cnt, 64'd0);
        rst_n = 1'b1;

        // Single requester 0: value and 2-cycle latency
        for (int i = 0; i < 5; i++) begin
            set_x(0, data_t'(xs[i]));
            req_valid = 4'b0001; out_ready = 1'b1;
            #1;
            check("single_ready", 64'(req_ready), 64'd1);
            tick();
            req_valid = 4'b0000;
            check("single_lat1_valid", 64'(out_valid), 64'd0);
            tick();
            check("single_valid", 64'(out_valid), 64'd1);
            check("single_y", 64'(out_y), 64'(ys[i]));
            check("single_id", 64'(out_id), 64'd0);
            tick();
        end

        // All four valid after reset: 0,1,2,3,0,1
        rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_x(i, data_t'(i * 1024));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 64'(req_ready), 64'(4'b0001 << order[k]));
            if (k >= 2) begin
                check("rr_out_valid", 64'(out_valid), 64'd1);
                check("rr_out_id", 64'(out_id), 64'(order[k-2]));
                check("rr_out_y", 64'(out_y), 64'(yv[order[k-2]]));
            end
            tick();
        end
        req_valid = 4'b0000;
        #1;
        check("rr_tail_id4", 64'(out_id), 64'(order[4]));
        tick();
        check("rr_tail_id5", 64'(out_id), 64'(order[5]));
        tick(); tick();

        // Pointer now 2 with requesters 1 and 3 valid
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("alt_ready", 64'(req_ready), 64'(alt[k]));
            tick();
        end
        req_valid = 4'b0000;
        tick(); tick(); tick();

        // Backpressure: two buffered operands, then drain in order
        out_ready = 1'b0; req_valid = 4'b1111; acc = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (req_ready != 4'b0000) acc++;
            if (k == 0) check("bp_ready0", 64'(req_ready), 64'd1);
            if (k == 1) check("bp_ready1", 64'(req_ready), 64'd2);
            if (k >= 2) begin
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_id", 64'(out_id), 64'd0);
                check("bp_hold_y", 64'(out_y), 64'd32768);
            end
            tick();
        end
        check("bp_accepts", 64'(acc), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 0) check("bp_release_ready", 64'(req_ready), 64'd4);
            check("bp_drain_valid", 64'(out_valid), 64'd1);
            check("bp_drain_id", 64'(out_id), 64'(k));
            check("bp_drain_y", 64'(out_y), 64'(yv[k]));
            tick();
        end

        // Reset with both stages full
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_y", 64'(out_y), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'd1);
        tick(); tick();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_id", 64'(out_id), 64'd0);
        check("post_rst_y", 64'(out_y), 64'd32768);
        req_valid = 4'b0000;
        tick(); tick(); tick();
        check("idle_end", 64'(idle), 64'd1);

`ifdef SIGMOID_ARB_STATS_EN
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_valid = 4'b0100;
        repeat (10) tick();
        check("cnt2_ten", 64'(grant_cnt[32 +: 16]), 64'd10);
        check("cnt_others", 64'({grant_cnt[63:48], grant_cnt[31:0]}), 64'd0);
        stats_clr = 1'b1;
        #1;
        check("clr_with_grant", 64'(req_ready), 64'd4);
        tick();
        stats_clr = 1'b0;
        check("cnt2_cleared", 64'(grant_cnt[32 +: 16]), 64'd0);
        req_valid = 4'b0000;
        tick();
`else
        check("cnt_tied_zero", grant_cnt, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
